// File: rtl/versatile_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// versatile_fifo_rd_stream : FIFO read-side consumer with 2-entry skid buffer
// Rev 1.0
// ============================================================================
module versatile_fifo_rd_stream #(
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic                  wr_busy,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [1:0]            level
);

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_e0;
  logic [DATA_WIDTH-1:0] r_e1;

  logic       w_pop;
  logic       w_push;
  logic [2:0] w_space;
  logic [1:0] w_occ_nxt;
  logic       w_ld_e0_q;
  logic       w_ld_e1_q;
  logic       w_shift;

  // Credit counts the in-flight word so occ + inflight never exceeds 2.
  always_comb begin
    w_pop   = r_valid & m_ready;
    w_push  = r_inflight;
    w_space = 3'd2 - {1'b0, r_occ} - {2'b00, r_inflight} + {2'b00, w_pop};
    fifo_rd = rst & ~fifo_empty & ~wr_busy & (w_space != 3'd0);
  end

  always_comb begin
    w_occ_nxt = r_occ;
    w_ld_e0_q = 1'b0;
    w_ld_e1_q = 1'b0;
    w_shift   = 1'b0;
    if (r_occ == 2'd0) begin
      if (w_push) begin
        w_occ_nxt = 2'd1;
        w_ld_e0_q = 1'b1;
      end
    end else if (r_occ == 2'd1) begin
      if (w_push && w_pop) begin
        w_occ_nxt = 2'd1;
        w_ld_e0_q = 1'b1;
      end else if (w_push) begin
        w_occ_nxt = 2'd2;
        w_ld_e1_q = 1'b1;
      end else if (w_pop) begin
        w_occ_nxt = 2'd0;
      end
    end else if (r_occ == 2'd2) begin
      if (w_pop && !w_push) begin
        w_occ_nxt = 2'd1;
        w_shift   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
      r_e0       <= '0;
      r_e1       <= '0;
    end else begin
      assert (!(w_push && (r_occ == 2'd2)));
      r_occ      <= w_occ_nxt;
      r_inflight <= fifo_rd;
      r_valid    <= (w_occ_nxt != 2'd0);
      if (w_ld_e0_q) begin
        r_e0 <= fifo_q;
      end else if (w_shift) begin
        r_e0 <= r_e1;
      end
      if (w_ld_e1_q) begin
        r_e1 <= fifo_q;
      end
    end
  end

  assign m_data  = r_e0;
  assign m_valid = r_valid;
  assign level   = r_occ;

endmodule
`default_nettype wire
